fp_norm128_seq: RTL and testbench

- Sequential normalizer that sits directly downstream of the registered quad-precision decompose stage.
- Accepts decomposed fields (sign, exponent, 113-bit fraction with hidden bit, class flags) over a valid/ready handshake.
- For denormals, left-shifts the fraction iteratively, STEP bits per cycle, until bit 112 is set, adjusting an extended signed exponent to match.
- All other classes pass through in one cycle. Output feeds the quad multiply/divide front-ends, which require normalized significands.

---
 rtl/fp_norm128_if.sv | 46 ++++
 rtl/fp_norm128_seq.sv | 123 ++++++++++++
 tb/tb_fp_norm128_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_norm128_if.sv
// Handshake and field bundle between the quad decompose stage, the
// sequential normalizer and the multiply/divide front-ends.
interface fp_norm128_if #(
    parameter int XW = 17
);
    // upstream side: decomposed operand fields
    logic           in_valid;
    logic           in_ready;
    logic           sgn_i;
    logic [14:0]    exp_i;
    logic [112:0]   fract_i;
    logic           xz_i;
    logic           vz_i;
    logic           inf_i;
    logic           nan_i;

    // downstream side: normalized result
    logic           out_valid;
    logic           out_ready;
    logic           sgn_o;
    logic [XW-1:0]  exp_o;
    logic [112:0]   fract_o;
    logic [6:0]     shift_o;
    logic           denorm_o;
    logic           vz_o;
    logic           inf_o;
    logic           nan_o;

    // view taken by the normalizer itself
    modport slave (
        input  in_valid, sgn_i, exp_i, fract_i, xz_i, vz_i, inf_i, nan_i,
        output in_ready,
        output out_valid, sgn_o, exp_o, fract_o, shift_o, denorm_o,
        output vz_o, inf_o, nan_o,
        input  out_ready
    );

    // view taken by whatever drives operands and consumes results
    modport master (
        output in_valid, sgn_i, exp_i, fract_i, xz_i, vz_i, inf_i, nan_i,
        input  in_ready,
        input  out_valid, sgn_o, exp_o, fract_o, shift_o, denorm_o,
        input  vz_o, inf_o, nan_o,
        output out_ready
    );
endinterface

// File: rtl/fp_norm128_seq.sv
// Sequential quad-precision normalizer: denormal fractions are left-shifted
// up to STEP bits per cycle until the hidden bit position (112) is set, with
// a signed extended exponent tracking the shift. Other classes pass through.
module fp_norm128_seq #(
    parameter int STEP = 8,
    parameter int XW   = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_norm128_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t         state_q, state_d;
    logic           sgn_q, sgn_d;
    logic [XW-1:0]  exp_q, exp_d;
    logic [112:0]   fract_q, fract_d;
    logic [6:0]     shift_q, shift_d;
    logic           denorm_q, denorm_d;
    logic           vz_q, vz_d;
    logic           inf_q, inf_d;
    logic           nan_q, nan_d;

    // top STEP bits of the fraction examined in one NORM iteration
    logic [STEP-1:0] win;
    logic [6:0]      lz;

    assign win = fract_q[112 -: STEP];

    // leading-zero count of the window; an all-zero window yields STEP,
    // so the same shift equation covers both the "keep going" and "finish" cases
    always_comb begin
        lz = 7'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (win[i]) lz = 7'(STEP - 1 - i);
        end
    end

    // next-state and datapath update
    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        exp_d    = exp_q;
        fract_d  = fract_q;
        shift_d  = shift_q;
        denorm_d = denorm_q;
        vz_d     = vz_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sgn_d   = bus.sgn_i;
                    fract_d = bus.fract_i;
                    shift_d = '0;
                    vz_d    = bus.vz_i;
                    inf_d   = bus.inf_i;
                    nan_d   = bus.nan_i;
                    if (bus.xz_i && !bus.vz_i) begin
                        exp_d    = XW'(1);
                        denorm_d = 1'b1;
                        state_d  = NORM;
                    end else begin
                        exp_d    = XW'(bus.exp_i);
                        denorm_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            NORM: begin
                if (fract_q == '0) begin
                    // malformed denormal with an empty fraction: never terminates otherwise
                    state_d = DONE;
                end else begin
                    fract_d = fract_q << lz;
                    exp_d   = exp_q - XW'(lz);
                    shift_d = shift_q + lz;
                    if (win != '0) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and result registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sgn_q    <= 1'b0;
            exp_q    <= '0;
            fract_q  <= '0;
            shift_q  <= '0;
            denorm_q <= 1'b0;
            vz_q     <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            exp_q    <= exp_d;
            fract_q  <= fract_d;
            shift_q  <= shift_d;
            denorm_q <= denorm_d;
            vz_q     <= vz_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sgn_o     = sgn_q;
    assign bus.exp_o     = exp_q;
    assign bus.fract_o   = fract_q;
    assign bus.shift_o   = shift_q;
    assign bus.denorm_o  = denorm_q;
    assign bus.vz_o      = vz_q;
    assign bus.inf_o     = inf_q;
    assign bus.nan_o     = nan_q;
endmodule

// File: tb/tb_fp_norm128_seq.sv
// Directed bench for fp_norm128_seq: a one-shot normalization model predicts
// each result, a negedge process compares every valid output cycle, and
// hand-computed literals pin the model on the key cases.
module tb_fp_norm128_seq;
    localparam int STEP = 8;
    localparam int XW   = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    fp_norm128_if #(.XW(XW)) bus ();

    fp_norm128_seq #(.STEP(STEP), .XW(XW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic [XW-1:0] e;
        logic [112:0]  f;
        logic [6:0]    sh;
        logic          dn;
        logic          vz;
        logic          inf;
        logic          nan;
        int            lat;
    } res_t;

    res_t want;
    res_t cap;

    // normalization done in one go: count leading zeros, shift, rebias
    function automatic res_t model(input logic s, input logic [14:0] e,
                                   input logic [112:0] f, input logic xz,
                                   input logic vz, input logic inf, input logic nan);
        res_t r;
        r.s = s; r.vz = vz; r.inf = inf; r.nan = nan;
        if (xz && !vz) begin
            int l = 0;
            while (l < 113 && f[112 - l] == 1'b0) l++;
            r.f   = f << l;
            r.e   = XW'(1 - l);
            r.sh  = 7'(l);
            r.dn  = 1'b1;
            r.lat = l / STEP + 2;
        end else begin
            r.f   = f;
            r.e   = XW'(e);
            r.sh  = '0;
            r.dn  = 1'b0;
            r.lat = 1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            chk("sgn_o",    128'(bus.sgn_o),    128'(want.s));
            chk("exp_o",    128'(bus.exp_o),    128'(want.e));
            chk("fract_o",  128'(bus.fract_o),  128'(want.f));
            chk("shift_o",  128'(bus.shift_o),  128'(want.sh));
            chk("denorm_o", 128'(bus.denorm_o), 128'(want.dn));
            chk("vz_o",     128'(bus.vz_o),     128'(want.vz));
            chk("inf_o",    128'(bus.inf_o),    128'(want.inf));
            chk("nan_o",    128'(bus.nan_o),    128'(want.nan));
            chk("in_ready_in_done", 128'(bus.in_ready), 128'(0));
        end
    end

    // present one operand and complete the accept edge
    task automatic accept(input logic s, input logic [14:0] e, input logic [112:0] f,
                          input logic xz, input logic vz, input logic inf, input logic nan);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
        want = model(s, e, f, xz, vz, inf, nan);
        bus.sgn_i = s; bus.exp_i = e; bus.fract_i = f;
        bus.xz_i = xz; bus.vz_i = vz; bus.inf_i = inf; bus.nan_i = nan;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // full transaction: accept, measure latency, hold in DONE, consume
    task automatic send(input logic s, input logic [14:0] e, input logic [112:0] f,
                        input logic xz, input logic vz, input logic inf, input logic nan,
                        input int hold, input bit pulse);
        int lat = 0;
        accept(s, e, f, xz, vz, inf, nan);
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        chk("latency", 128'(lat), 128'(want.lat));
        cap.s = bus.sgn_o; cap.e = bus.exp_o; cap.f = bus.fract_o; cap.sh = bus.shift_o;
        cap.dn = bus.denorm_o; cap.vz = bus.vz_o; cap.inf = bus.inf_o; cap.nan = bus.nan_o;
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 2) begin
                bus.sgn_i = ~s; bus.exp_i = 15'h1234; bus.fract_i = ~f;
                bus.xz_i = 1'b1; bus.vz_i = 1'b0; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", 128'(bus.out_valid), 128'(0));
        chk("ready_back", 128'(bus.in_ready), 128'(1));
        if (pulse) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_stray_capture", 128'(bus.out_valid), 128'(0));
            end
        end
        txn++;
        $display("txn %0d: exp_o=%h shift_o=%0d denorm=%0d vz=%0d inf=%0d nan=%0d lat=%0d",
                 txn, cap.e, cap.sh, cap.dn, cap.vz, cap.inf, cap.nan, lat);
    endtask

    initial begin
        logic [112:0] one_top;
        logic [112:0] f;
        one_top = 113'd1 << 112;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.sgn_i = 1'b0; bus.exp_i = '0; bus.fract_i = '0;
        bus.xz_i = 1'b0; bus.vz_i = 1'b0; bus.inf_i = 1'b0; bus.nan_i = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_exp_o",     128'(bus.exp_o),     128'(0));
        chk("rst_fract_o",   128'(bus.fract_o),   128'(0));
        chk("rst_shift_o",   128'(bus.shift_o),   128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // normal operand
        send(1'b0, 15'h3FFF, one_top, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        chk("lit_norm_exp",   128'(cap.e),  128'(17'h03FFF));
        chk("lit_norm_shift", 128'(cap.sh), 128'(0));
        chk("lit_norm_dn",    128'(cap.dn), 128'(0));

        // smallest denormal
        send(1'b1, 15'h0, 113'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("lit_d1_shift", 128'(cap.sh), 128'(112));
        chk("lit_d1_exp",   128'(cap.e),  128'(17'h1FF91));
        chk("lit_d1_fract", 128'(cap.f),  128'(one_top));
        chk("lit_d1_dn",    128'(cap.dn), 128'(1));

        // denormal with bit 100 only: 8 then 4
        f = 113'd1 << 100;
        send(1'b0, 15'h0, f, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("lit_d100_shift", 128'(cap.sh), 128'(12));
        chk("lit_d100_exp",   128'(cap.e),  128'(17'h1FFF5));

        // window-boundary denormals: L=7 (one NORM cycle) and L=8 (two)
        f = (113'd1 << 105) | 113'h5A5;
        send(1'b0, 15'h0, f, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("lit_d105_shift", 128'(cap.sh), 128'(7));
        f = (113'd1 << 104) | 113'h3;
        send(1'b1, 15'h0, f, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("lit_d104_shift", 128'(cap.sh), 128'(8));
        chk("lit_d104_exp",   128'(cap.e),  128'(17'h1FFF9));

        // zero, infinity, NaN pass straight through
        send(1'b1, 15'h0, 113'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        chk("lit_zero_vz",  128'(cap.vz), 128'(1));
        chk("lit_zero_exp", 128'(cap.e),  128'(0));
        send(1'b0, 15'h7FFF, 113'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        chk("lit_inf", 128'(cap.inf), 128'(1));
        f = 113'd1 << 111;
        send(1'b0, 15'h7FFF, f, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        chk("lit_nan",       128'(cap.nan), 128'(1));
        chk("lit_nan_fract", 128'(cap.f),   128'(f));

        // long stall in DONE with a stray in_valid pulse
        f = one_top | 113'h1234_5678_9ABC;
        send(1'b1, 15'h4001, f, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1);

        // asynchronous reset during the 5th NORM cycle of the smallest denormal
        accept(1'b0, 15'h0, 113'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  128'(bus.out_valid), 128'(0));
        chk("mid_rst_exp",    128'(bus.exp_o),     128'(0));
        chk("mid_rst_fract",  128'(bus.fract_o),   128'(0));
        chk("mid_rst_shift",  128'(bus.shift_o),   128'(0));
        chk("mid_rst_denorm", 128'(bus.denorm_o),  128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 128'(bus.in_ready),  128'(1));
        chk("post_rst_valid", 128'(bus.out_valid), 128'(0));
        send(1'b0, 15'h3FFE, one_top | 113'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("lit_post_exp", 128'(cap.e), 128'(17'h03FFE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
